// File: rtl/mux_serializer_16.sv
// mux_serializer_16: parallel-to-serial front end for a 16:1 bit-select mux.
// Captures a word via valid/ready, holds it on mux_data and walks mux_sel
// one beat per ser_valid/ser_ready handshake. The mux output bit (mux_bit)
// is forwarded as ser_data.
// Optional feature: define SERIAL_PARITY_EN to append an even-parity beat.
module mux_serializer_16 #(
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] load_data,
  input  logic        load_valid,
  output logic        load_ready,
  output logic [15:0] mux_data,
  output logic [3:0]  mux_sel,
  input  logic        mux_bit,
  output logic        ser_data,
  output logic        ser_valid,
  output logic        ser_last,
  input  logic        ser_ready
);

  localparam logic [3:0] START_IDX = (LSB_FIRST != 0) ? 4'd0  : 4'd15;
  localparam logic [3:0] END_IDX   = (LSB_FIRST != 0) ? 4'd15 : 4'd0;

`ifdef SERIAL_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  logic parity_q;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t state_q, state_d;
  logic   sel_at_end;
  logic   load_fire;

  assign sel_at_end = (mux_sel == END_IDX);

  // Output decode and next-state logic; outputs depend on registers only,
  // except load_ready which also looks at ser_ready on the final beat.
  always_comb begin
    ser_valid = 1'b0;
    ser_data  = 1'b0;
    ser_last  = 1'b0;
    state_d   = state_q;
    case (state_q)
      IDLE: begin
      end
      SHIFT: begin
        ser_valid = 1'b1;
        ser_data  = mux_bit;
`ifdef SERIAL_PARITY_EN
        ser_last  = 1'b0;
`else
        ser_last  = sel_at_end;
`endif
      end
`ifdef SERIAL_PARITY_EN
      PARITY: begin
        ser_valid = 1'b1;
        ser_data  = parity_q;
        ser_last  = 1'b1;
      end
`endif
      default: begin
      end
    endcase

    load_ready = (state_q == IDLE) || (ser_last && ser_ready);
    load_fire  = load_valid && load_ready;

    case (state_q)
      IDLE: begin
        if (load_fire) state_d = SHIFT;
      end
      SHIFT: begin
        if (ser_ready && sel_at_end) begin
`ifdef SERIAL_PARITY_EN
          state_d = PARITY;
`else
          state_d = load_fire ? SHIFT : IDLE;
`endif
        end
      end
`ifdef SERIAL_PARITY_EN
      PARITY: begin
        if (ser_ready) state_d = load_fire ? SHIFT : IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Word and select registers: a load takes precedence, otherwise the
  // select steps on every data-beat handshake except the final one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_data <= '0;
      mux_sel  <= '0;
    end else if (load_fire) begin
      mux_data <= load_data;
      mux_sel  <= START_IDX;
    end else if (state_q == SHIFT && ser_ready && !sel_at_end) begin
      if (LSB_FIRST != 0) mux_sel <= mux_sel + 4'd1;
      else                mux_sel <= mux_sel - 4'd1;
    end
  end

`ifdef SERIAL_PARITY_EN
  // Even-parity accumulator over the data beats of the current word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else if (load_fire) begin
      parity_q <= 1'b0;
    end else if (state_q == SHIFT && ser_ready) begin
      parity_q <= parity_q ^ mux_bit;
    end
  end
`endif

endmodule

// File: tb/tb_mux_serializer_16.sv
// Directed testbench for mux_serializer_16. Instance a is LSB-first,
// instance b is MSB-first; both share stimulus and each has its own mux model.
module tb_mux_serializer_16;

`ifdef SERIAL_PARITY_EN
  localparam int NB = 17;
`else
  localparam int NB = 16;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] load_data;
  logic        load_valid;
  logic        ser_ready;

  logic        a_load_ready, a_ser_data, a_ser_valid, a_ser_last, a_mux_bit;
  logic [15:0] a_mux_data;
  logic [3:0]  a_mux_sel;
  logic        b_load_ready, b_ser_data, b_ser_valid, b_ser_last, b_mux_bit;
  logic [15:0] b_mux_data;
  logic [3:0]  b_mux_sel;

  int checks = 0;
  int failures = 0;

  assign a_mux_bit = a_mux_data[a_mux_sel];
  assign b_mux_bit = b_mux_data[b_mux_sel];

  mux_serializer_16 #(.LSB_FIRST(1)) u_a (
    .clk(clk), .rst_n(rst_n), .load_data(load_data), .load_valid(load_valid),
    .load_ready(a_load_ready), .mux_data(a_mux_data), .mux_sel(a_mux_sel),
    .mux_bit(a_mux_bit), .ser_data(a_ser_data), .ser_valid(a_ser_valid),
    .ser_last(a_ser_last), .ser_ready(ser_ready)
  );

  mux_serializer_16 #(.LSB_FIRST(0)) u_b (
    .clk(clk), .rst_n(rst_n), .load_data(load_data), .load_valid(load_valid),
    .load_ready(b_load_ready), .mux_data(b_mux_data), .mux_sel(b_mux_sel),
    .mux_bit(b_mux_bit), .ser_data(b_ser_data), .ser_valid(b_ser_valid),
    .ser_last(b_ser_last), .ser_ready(ser_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load one word from IDLE and consume it, optionally stalling stall_len
  // cycles when beat index stall_at is presented.
  task automatic run_word(input string tag, input logic [15:0] word, input logic par,
                          input int stall_at, input int stall_len);
    int beat;
    int cyc;
    int stalls;
    logic exp_bit;
    load_data  = word;
    load_valid = 1'b1;
    ser_ready  = 1'b1;
    #1;
    chk({tag, "_ready_idle"}, 32'(a_load_ready), 32'd1);
    step();
    load_valid = 1'b0;
    load_data  = 16'h0;
    #1;
    chk({tag, "_held"}, 32'(a_mux_data), 32'(word));
    beat = 0;
    cyc = 0;
    stalls = 0;
    while (a_ser_valid && cyc < NB + stall_len + 8) begin
      if (beat == stall_at && stalls < stall_len) begin
        ser_ready = 1'b0;
        #1;
        chk({tag, "_stall_sel"}, 32'(a_mux_sel), 32'(beat));
        chk({tag, "_stall_data"}, 32'(a_ser_data), 32'(word[beat[3:0]]));
        chk({tag, "_stall_ready"}, 32'(a_load_ready), 32'd0);
        stalls++;
      end else begin
        ser_ready = 1'b1;
        #1;
        exp_bit = (beat < 16) ? word[beat[3:0]] : par;
        chk({tag, "_data"}, 32'(a_ser_data), 32'(exp_bit));
        chk({tag, "_last"}, 32'(a_ser_last), 32'(beat == NB - 1));
        chk({tag, "_load_ready"}, 32'(a_load_ready), 32'(beat == NB - 1));
        if (beat < 16) chk({tag, "_sel"}, 32'(a_mux_sel), 32'(beat));
        beat++;
      end
      step();
      cyc++;
    end
    chk({tag, "_cycles"}, 32'(cyc), 32'(NB + stall_len));
    chk({tag, "_beats"}, 32'(beat), 32'(NB));
    chk({tag, "_idle"}, 32'(a_ser_valid), 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    load_data  = 16'h0;
    load_valid = 1'b0;
    ser_ready  = 1'b0;
    #1;
    chk("rst_valid", 32'(a_ser_valid), 32'd0);
    chk("rst_last", 32'(a_ser_last), 32'd0);
    chk("rst_ready", 32'(a_load_ready), 32'd1);
    chk("rst_data", 32'(a_mux_data), 32'h0);
    chk("rst_sel", 32'(a_mux_sel), 32'h0);
    chk("rst_sel_b", 32'(b_mux_sel), 32'h0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // A5C3 LSB-first: 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; parity of 8 ones = 0
    run_word("basic", 16'hA5C3, 1'b0, -1, 0);

    // 8001 with 3-cycle stall at beat 5 (mux_sel = 4, bit = 0)
    run_word("bp", 16'h8001, 1'b0, 4, 3);

    // Back-to-back FFFF then 0000 with load_valid held
    load_data  = 16'hFFFF;
    load_valid = 1'b1;
    ser_ready  = 1'b1;
    step();
    load_data = 16'h0000;
    for (int i = 0; i < 2 * NB; i++) begin
      if (i == 2 * NB - 1) load_valid = 1'b0;
      #1;
      chk("b2b_valid", 32'(a_ser_valid), 32'd1);
      chk("b2b_data", 32'(a_ser_data), 32'(i < 16));
      chk("b2b_load_ready", 32'(a_load_ready), 32'((i % NB) == NB - 1));
      step();
    end
    chk("b2b_idle", 32'(a_ser_valid), 32'd0);

    // MSB-first on instance b: 8000 -> 1 then 15 zeros; parity 1
    load_data  = 16'h8000;
    load_valid = 1'b1;
    #1;
    chk("msb_ready", 32'(b_load_ready), 32'd1);
    step();
    load_valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      #1;
      chk("msb_valid", 32'(b_ser_valid), 32'd1);
      if (i < 16) begin
        chk("msb_sel", 32'(b_mux_sel), 32'(15 - i));
        chk("msb_data", 32'(b_ser_data), 32'(i == 0));
      end else begin
        chk("msb_parity", 32'(b_ser_data), 32'd1);
      end
      chk("msb_last", 32'(b_ser_last), 32'(i == NB - 1));
      step();
    end
    chk("msb_idle", 32'(b_ser_valid), 32'd0);

    // Reset at beat 7 of 1234
    load_data  = 16'h1234;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("mid_sel", 32'(a_mux_sel), 32'd6);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(a_ser_valid), 32'd0);
    chk("mid_rst_last", 32'(a_ser_last), 32'd0);
    chk("mid_rst_ready", 32'(a_load_ready), 32'd1);
    chk("mid_rst_data", 32'(a_mux_data), 32'h0);
    chk("mid_rst_sel", 32'(a_mux_sel), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    run_word("reload", 16'h0001, 1'b1, -1, 0);

`ifdef SERIAL_PARITY_EN
    run_word("par7", 16'h0007, 1'b1, -1, 0);
    run_word("par3", 16'h0003, 1'b0, -1, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mux_serializer_16.md
# mux_serializer_16

Parallel-to-serial front end for the 16:1 bit-select mux. It captures a 16-bit word through a valid/ready handshake, holds it on the mux data inputs, and walks the mux select from 0 to 15. Each mux output bit is forwarded as one serial beat, with backpressure and an end-of-word marker. The block sits both upstream of the mux (driving its data and select) and downstream of it (consuming its output bit).

## Interface
Parameters:
- `LSB_FIRST`, default 1: 1 = select counts 0→15; 0 = select counts 15→0.

Ports:
- `clk`  in  1  — single clock; all state on rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `load_data`  in  16  — parallel word to serialize.
- `load_valid`  in  1  — `load_data` is valid.
- `load_ready`  out  1  — block can accept a word this cycle.
- `mux_data`  out  16  — held word; drives the mux `data_in`.
- `mux_sel`  out  4  — drives the mux `select`.
- `mux_bit`  in  1  — the mux `data_out`, combinational from `mux_data`/`mux_sel`.
- `ser_data`  out  1  — serial bit, equal to `mux_bit` (parity bit on the parity beat).
- `ser_valid`  out  1  — `ser_data` is valid.
- `ser_last`  out  1  — final beat of the current word.
- `ser_ready`  in  1  — downstream accepts the beat.

## Operation
- State machine: `IDLE`, `SHIFT` (plus `PARITY` when configured).
- **IDLE**
  - `load_ready`=1, `ser_valid`=0.
  - On `load_valid && load_ready`: `mux_data`←`load_data`, `mux_sel`←start index (0 if `LSB_FIRST`, else 15), go to `SHIFT`.
- **SHIFT**
  - `ser_valid`=1 and `ser_data`=`mux_bit`.
  - A beat completes only on `ser_valid && ser_ready`; `mux_sel` then steps by +1 (`LSB_FIRST`) or -1.
  - With `ser_ready`=0, `mux_sel`, `mux_data`, `ser_data` and `ser_last` hold stable.
  - `ser_last`=1 when `mux_sel` is at the end index (15 or 0) and no parity beat follows.
- **End of word:** on the last beat's handshake:
  - If `load_valid`=1, the next word loads in the same cycle (back-to-back) and the state stays `SHIFT`.
  - Otherwise the state returns to `IDLE`.
- **`load_ready`** = (state==`IDLE`) || (final beat && `ser_ready`). It is combinational, with no dependency on `load_valid`.
- `mux_data` is not altered mid-word; a `load_valid` asserted mid-word waits.
- `mux_sel` never wraps mid-word. It is reloaded only on a load.
- **Reset (any time, including mid-word):** state→`IDLE`, `mux_data`=16'h0000, `mux_sel`=0, `ser_valid`=0, `ser_last`=0, `load_ready`=1, parity accumulator=0. A partial word is discarded.

## Timing
- Load accepted at edge N → `ser_valid`=1 from cycle N+1 with bit `load_data[start index]`.
- With `ser_ready` held at 1: 16 beats in cycles N+1..N+16 (17 with parity).
- Back-to-back words have zero idle cycles between them.
- `ser_data` is a combinational path: `mux_sel`/`mux_data` registers → mux → `ser_data`. There are no additional pipeline registers.
- `ser_valid` and `ser_last` are decoded from registers only, with no combinational path from `ser_ready`.

## Configuration
- Macro `SERIAL_PARITY_EN`:
  - **Defined:**
    - An even-parity bit (XOR of all 16 data bits) is sent as a 17th beat in state `PARITY`.
    - `ser_last`=1 only on that beat, not on the 16th data beat.
    - The accumulator updates on each data-beat handshake.
  - **Undefined:** no `PARITY` state, no accumulator; 16 beats per word, and `ser_last` is on data beat 16.

## Test plan
- **Basic LSB-first:** reset, load 16'hA5C3, `ser_ready`=1.
  - Expect beats 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
  - `ser_last` on beat 16 only.
  - `load_ready`=0 during beats 1..15.
- **Backpressure:** load 16'h8001, drop `ser_ready` for 3 cycles at beat 5.
  - `mux_sel`=4 and `ser_data`=0 hold for those 3 cycles.
  - Total word takes 19 cycles and the stream is unchanged.
- **Back-to-back:** `load_valid` held with 16'hFFFF then 16'h0000.
  - 32 consecutive valid beats: 16 ones then 16 zeros.
  - `load_ready` pulses on beat 16.
- **MSB-first (`LSB_FIRST`=0):** load 16'h8000 → first beat 1, then 15 zeros; `mux_sel` goes 15→0.
- **Reset mid-word:** assert `rst_n`=0 at beat 7 of 16'h1234.
  - All outputs immediately at their reset values.
  - After release, loading 16'h0001 gives first beat 1 with no stale bits.
- **`SERIAL_PARITY_EN`:**
  - Load 16'h0007 → beat 17 = 1 with `ser_last` on it.
  - Load 16'h0003 → beat 17 = 0.
